hazard_pipe: RTL and testbench
==============================

HAZARD_PIPE -- requirements
Module: hazard_pipe

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have inputs rs_D, rt_D, rIR_D (5 bits each): the D-stage source registers and destination register.
REQ-004 SHALL have inputs regWrite_D (1 bit) and tNew_D (2 bits): the D-stage write enable and cycles-until-result.
REQ-005 SHALL have input stall_in (1 bit): the stall request from the hazard unit.
REQ-006 SHALL have outputs rs_E, rt_E, rt_M, rIR_E, rIR_M, rIR_W (5 bits each): the per-stage register fields.
REQ-007 SHALL have outputs regWrite_E, regWrite_M, regWrite_W (1 bit each) and tNew_E, tNew_M (2 bits each).
REQ-008 SHALL have output stall (1 bit): the final stall, which the F/D registers hold on and which inserts the E bubble.

Function
REQ-009 SHALL register the D fields into E on every clk edge when stall=0.
REQ-010 SHALL load a bubble into E (all fields 0, regWrite_E=0, tNew_E=0) on a clk edge when stall=1.
REQ-011 SHALL advance E->M and M->W unconditionally on every clk edge; stall never freezes M or W.
REQ-012 SHALL compute tNew_M on the E->M transfer as tNew_E-1, saturating at 0, and SHALL not track tNew in W (W result is always ready).
REQ-013 SHALL mask regWrite_x to 0 whenever rIR_x==0, in every stage.
REQ-014 SHALL drive stall = stall_in | stall_md; stall_md is 0 when the MDU feature is absent.
REQ-015 SHALL keep all stall logic combinational from current inputs/state, with zero added cycles of latency.
REQ-016 SHALL have each instruction visible in E exactly 1 cycle after acceptance, in M after 2, and in W after 3.

Reset
REQ-017 SHALL, while rst_n=0, asynchronously force all E/M/W fields to 0, all regWrite to 0 and all tNew to 0.
REQ-018 SHALL, while rst_n=0 and under HAZARD_PIPE_MDU_EN, clear the MDU busy counter to 0, so md_busy=0.
REQ-019 SHALL treat a reset asserted mid-operation as discarding all in-flight instructions, including an MDU operation in progress.
REQ-020 SHALL resume normal behaviour on the first clk edge after rst_n rises.

Configuration
REQ-021 SHALL, when macro HAZARD_PIPE_MDU_EN is defined, add inputs md_start_D (D holds mult/div), md_div_D (1 = divide) and md_use_D (D holds mult/div/mfhi/mflo/mthi/mtlo).
REQ-022 SHALL, under HAZARD_PIPE_MDU_EN, add output md_busy and load a 4-bit counter when a start instruction is accepted into E: 5 for multiply, 10 for divide.
REQ-023 SHALL, under HAZARD_PIPE_MDU_EN, decrement the counter by 1 per cycle down to 0.
REQ-024 SHALL drive md_busy = (counter!=0) | start_E, where start_E is the registered md_start_D.
REQ-025 SHALL drive stall_md = md_use_D & md_busy.
REQ-026 SHALL ignore a new start that arrives while busy; it cannot occur because stall_md blocks it.
REQ-027 SHALL, without HAZARD_PIPE_MDU_EN, omit the MDU ports and counter and tie stall_md to 0.

Structure
REQ-028 SHALL place the MDU latency constants (MUL_CYC=5, DIV_CYC=10) and the 5-bit register-index and 2-bit tNew widths in the shared macro.v package.
REQ-029 SHALL implement the MDU busy counter as sub-module md_busy_ctr, instantiated only under HAZARD_PIPE_MDU_EN.

Verification
REQ-030 SHALL cover: rIR_D=8, regWrite_D=1, tNew_D=2 accepted -> next cycle rIR_E=8, tNew_E=2; then rIR_M=8, tNew_M=1; then rIR_W=8, regWrite_W=1.
REQ-031 SHALL cover: stall_in=1 for 1 cycle with an instruction in M -> E bubble (rIR_E=0, regWrite_E=0) while M advances to W.
REQ-032 SHALL cover: rIR_D=0, regWrite_D=1 -> regWrite_E, regWrite_M and regWrite_W all stay 0.
REQ-033 SHALL cover: tNew_D=0 accepted -> tNew_M=0 (saturation, no wrap to 3).
REQ-034 SHALL cover, under MDU_EN: a div accepted, then mflo in D -> stall=1 for exactly 11 cycles, and mflo reaches E on the 12th edge.
REQ-035 SHALL cover: rst_n pulsed low mid-division -> md_busy=0 and all stage fields 0 immediately, with no clk edge needed.

Source files
------------

// File: rtl/hazard_pipe_pkg.sv
// hazard_pipe_pkg -- shared widths, MDU latency constants and stage types
// for the D/E/M/W hazard-tracking pipeline (hazard_pipe).
//
// Contents:
//   REG_W / TNEW_W : register-index and cycles-until-result widths
//   MUL_CYC/DIV_CYC: MDU busy cycles loaded for multiply / divide
//   e_stage_t      : packed E-stage register bundle
//   tnew_dec       : saturating decrement of a tNew value
package hazard_pipe_pkg;

    localparam int unsigned REG_W   = 5;
    localparam int unsigned TNEW_W  = 2;
    localparam int unsigned CTR_W   = 4;
    localparam int unsigned MUL_CYC = 5;
    localparam int unsigned DIV_CYC = 10;

    typedef logic [REG_W-1:0]  reg_idx_t;
    typedef logic [TNEW_W-1:0] tnew_t;

    typedef struct packed {
        reg_idx_t rs;
        reg_idx_t rt;
        reg_idx_t rIR;
        logic     regWrite;
        tnew_t    tNew;
    } e_stage_t;

    // One stage closer to the result; never wraps below zero.
    function automatic tnew_t tnew_dec(input tnew_t t);
        return (t == '0) ? '0 : tnew_t'(t - 1'b1);
    endfunction

endpackage

// File: rtl/hazard_pipe_md_busy_ctr.sv
// md_busy_ctr -- multiply/divide unit busy counter.
//
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset, clears the counter
//   start_e_i : a mult/div start instruction currently sits in E
//   div_e_i   : that start is a divide (1) or multiply (0)
//   busy_o    : MDU busy = counter non-zero or a start waiting in E
module md_busy_ctr
    import hazard_pipe_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic start_e_i,
    input  logic div_e_i,
    output logic busy_o
);

    logic [CTR_W-1:0] ctr_q;
    logic [CTR_W-1:0] ctr_d;

    // The counter is loaded as the start leaves E, so busy covers the E
    // cycle (via start_e_i) plus the full latency afterwards. A start seen
    // while still counting is ignored.
    always_comb begin
        ctr_d = ctr_q;
        if (start_e_i && (ctr_q == '0)) begin
            ctr_d = div_e_i ? CTR_W'(DIV_CYC) : CTR_W'(MUL_CYC);
        end else if (ctr_q != '0) begin
            ctr_d = ctr_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr_q <= '0;
        end else begin
            ctr_q <= ctr_d;
        end
    end

    assign busy_o = (ctr_q != '0) | start_e_i;

endmodule

// File: rtl/hazard_pipe.sv
// hazard_pipe -- E/M/W register-field pipeline feeding a hazard unit.
//
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   rs_D, rt_D, rIR_D          : D-stage sources and destination
//   regWrite_D, tNew_D         : D-stage write enable, cycles-until-result
//   stall_in                   : stall request from the hazard unit
//   rs_E, rt_E, rIR_E, ...     : per-stage register fields (E, M, W)
//   regWrite_E/M/W, tNew_E/M   : per-stage write enables and tNew
//   stall                      : final stall (holds F/D, bubbles E)
//   md_start_D, md_div_D,
//   md_use_D, md_busy          : MDU interface, only with HAZARD_PIPE_MDU_EN
//
// Optional feature macro: HAZARD_PIPE_MDU_EN (adds the MDU busy stall).
module hazard_pipe
    import hazard_pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_W-1:0]  rs_D,
    input  logic [REG_W-1:0]  rt_D,
    input  logic [REG_W-1:0]  rIR_D,
    input  logic              regWrite_D,
    input  logic [TNEW_W-1:0] tNew_D,
    input  logic              stall_in,
    output logic [REG_W-1:0]  rs_E,
    output logic [REG_W-1:0]  rt_E,
    output logic [REG_W-1:0]  rt_M,
    output logic [REG_W-1:0]  rIR_E,
    output logic [REG_W-1:0]  rIR_M,
    output logic [REG_W-1:0]  rIR_W,
    output logic              regWrite_E,
    output logic              regWrite_M,
    output logic              regWrite_W,
    output logic [TNEW_W-1:0] tNew_E,
    output logic [TNEW_W-1:0] tNew_M,
`ifdef HAZARD_PIPE_MDU_EN
    input  logic              md_start_D,
    input  logic              md_div_D,
    input  logic              md_use_D,
    output logic              md_busy,
`endif
    output logic              stall
);

    e_stage_t e_q, e_d;

    reg_idx_t rt_M_q, rIR_M_q, rIR_W_q;
    logic     regWrite_M_q, regWrite_W_q;
    tnew_t    tNew_M_q;

    logic     stall_md;

`ifdef HAZARD_PIPE_MDU_EN
    logic start_E_q, start_E_d;
    logic div_E_q, div_E_d;
    logic md_busy_w;

    md_busy_ctr u_md_busy_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_e_i (start_E_q),
        .div_e_i   (div_E_q),
        .busy_o    (md_busy_w)
    );

    assign stall_md = md_use_D & md_busy_w;
    assign md_busy  = md_busy_w;

    always_comb begin
        start_E_d = 1'b0;
        div_E_d   = 1'b0;
        if (!stall) begin
            start_E_d = md_start_D;
            div_E_d   = md_div_D;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_E_q <= 1'b0;
            div_E_q   <= 1'b0;
        end else begin
            start_E_q <= start_E_d;
            div_E_q   <= div_E_d;
        end
    end
`else
    assign stall_md = 1'b0;
`endif

    assign stall = stall_in | stall_md;

    // Masking regWrite on entry keeps it masked in M and W as well, since
    // rIR travels unchanged with it.
    always_comb begin
        e_d = '0;
        if (!stall) begin
            e_d.rs       = rs_D;
            e_d.rt       = rt_D;
            e_d.rIR      = rIR_D;
            e_d.regWrite = regWrite_D & (rIR_D != '0);
            e_d.tNew     = tNew_D;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q          <= '0;
            rt_M_q       <= '0;
            rIR_M_q      <= '0;
            regWrite_M_q <= 1'b0;
            tNew_M_q     <= '0;
            rIR_W_q      <= '0;
            regWrite_W_q <= 1'b0;
        end else begin
            e_q          <= e_d;
            rt_M_q       <= e_q.rt;
            rIR_M_q      <= e_q.rIR;
            regWrite_M_q <= e_q.regWrite;
            tNew_M_q     <= tnew_dec(e_q.tNew);
            rIR_W_q      <= rIR_M_q;
            regWrite_W_q <= regWrite_M_q;
        end
    end

    assign rs_E       = e_q.rs;
    assign rt_E       = e_q.rt;
    assign rIR_E      = e_q.rIR;
    assign regWrite_E = e_q.regWrite;
    assign tNew_E     = e_q.tNew;
    assign rt_M       = rt_M_q;
    assign rIR_M      = rIR_M_q;
    assign regWrite_M = regWrite_M_q;
    assign tNew_M     = tNew_M_q;
    assign rIR_W      = rIR_W_q;
    assign regWrite_W = regWrite_W_q;

endmodule

// File: tb/tb_hazard_pipe.sv
// tb_hazard_pipe -- directed self-checking bench for hazard_pipe.
// MDU sequences are exercised when HAZARD_PIPE_MDU_EN is defined.
module tb_hazard_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [4:0] rs_D = '0, rt_D = '0, rIR_D = '0;
    logic       regWrite_D = 1'b0;
    logic [1:0] tNew_D = '0;
    logic       stall_in = 1'b0;
    logic [4:0] rs_E, rt_E, rt_M, rIR_E, rIR_M, rIR_W;
    logic       regWrite_E, regWrite_M, regWrite_W;
    logic [1:0] tNew_E, tNew_M;
    logic       stall;
`ifdef HAZARD_PIPE_MDU_EN
    logic       md_start_D = 1'b0, md_div_D = 1'b0, md_use_D = 1'b0;
    logic       md_busy;
    int         n;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rs_D       (rs_D),
        .rt_D       (rt_D),
        .rIR_D      (rIR_D),
        .regWrite_D (regWrite_D),
        .tNew_D     (tNew_D),
        .stall_in   (stall_in),
        .rs_E       (rs_E),
        .rt_E       (rt_E),
        .rt_M       (rt_M),
        .rIR_E      (rIR_E),
        .rIR_M      (rIR_M),
        .rIR_W      (rIR_W),
        .regWrite_E (regWrite_E),
        .regWrite_M (regWrite_M),
        .regWrite_W (regWrite_W),
        .tNew_E     (tNew_E),
        .tNew_M     (tNew_M),
`ifdef HAZARD_PIPE_MDU_EN
        .md_start_D (md_start_D),
        .md_div_D   (md_div_D),
        .md_use_D   (md_use_D),
        .md_busy    (md_busy),
`endif
        .stall      (stall)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic rw, input logic [1:0] tn);
        rs_D = rs; rt_D = rt; rIR_D = rd; regWrite_D = rw; tNew_D = tn;
    endtask

    initial begin
        // asynchronous reset, checked before any clock edge
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_rIR_E", rIR_E, 0);
        check_eq("rst_rIR_W", rIR_W, 0);
        check_eq("rst_stall", stall, 0);
        step(); step();
        rst_n = 1'b1;

        // basic flow with tNew decrement
        set_d(5'd3, 5'd4, 5'd8, 1'b1, 2'd2);
        step();
        check_eq("E_rIR", rIR_E, 8);
        check_eq("E_rs", rs_E, 3);
        check_eq("E_rt", rt_E, 4);
        check_eq("E_tNew", tNew_E, 2);
        check_eq("E_rw", regWrite_E, 1);
        set_d(5'd0, 5'd0, 5'd0, 1'b0, 2'd0);
        step();
        check_eq("M_rIR", rIR_M, 8);
        check_eq("M_rt", rt_M, 4);
        check_eq("M_tNew", tNew_M, 1);
        check_eq("M_rw", regWrite_M, 1);
        step();
        check_eq("W_rIR", rIR_W, 8);
        check_eq("W_rw", regWrite_W, 1);

        // tNew saturation
        set_d(5'd1, 5'd2, 5'd5, 1'b1, 2'd0);
        step();
        check_eq("sat_tNewE", tNew_E, 0);
        set_d(5'd0, 5'd0, 5'd0, 1'b0, 2'd0);
        step();
        check_eq("sat_rIRM", rIR_M, 5);
        check_eq("sat_tNewM", tNew_M, 0);

        // destination $0 never writes
        set_d(5'd1, 5'd2, 5'd0, 1'b1, 2'd3);
        step();
        check_eq("r0_rwE", regWrite_E, 0);
        step();
        check_eq("r0_rwM", regWrite_M, 0);
        step();
        check_eq("r0_rwW", regWrite_W, 0);

        // stall bubble while M/W keep moving
        set_d(5'd1, 5'd2, 5'd9, 1'b1, 2'd1);
        step();
        set_d(5'd3, 5'd4, 5'd10, 1'b1, 2'd2);
        step();
        set_d(5'd6, 5'd7, 5'd11, 1'b1, 2'd1);
        stall_in = 1'b1;
        #1;
        check_eq("stl_out", stall, 1);
        step();
        stall_in = 1'b0;
        check_eq("stl_rIRE", rIR_E, 0);
        check_eq("stl_rwE", regWrite_E, 0);
        check_eq("stl_tNewE", tNew_E, 0);
        check_eq("stl_rIRM", rIR_M, 10);
        check_eq("stl_tNewM", tNew_M, 1);
        check_eq("stl_rIRW", rIR_W, 9);
        check_eq("stl_clr", stall, 0);
        step();
        check_eq("rel_rIRE", rIR_E, 11);
        check_eq("rel_rIRM", rIR_M, 0);
        check_eq("rel_rIRW", rIR_W, 10);

        // asynchronous reset mid-stream, no clock edge
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_rIRE", rIR_E, 0);
        check_eq("arst_rIRM", rIR_M, 0);
        check_eq("arst_rIRW", rIR_W, 0);
        check_eq("arst_rwW", regWrite_W, 0);
        step();
        rst_n = 1'b1;
        set_d(5'd0, 5'd0, 5'd0, 1'b0, 2'd0);
        step();
        check_eq("post_rst_rIRE", rIR_E, 0);

`ifdef HAZARD_PIPE_MDU_EN
        // divide then mflo: stalled 11 cycles, mflo enters E on the 12th edge
        md_start_D = 1'b1; md_div_D = 1'b1; md_use_D = 1'b1;
        set_d(5'd1, 5'd2, 5'd0, 1'b0, 2'd0);
        step();
        md_start_D = 1'b0; md_div_D = 1'b0; md_use_D = 1'b1;
        set_d(5'd0, 5'd0, 5'd12, 1'b1, 2'd1);
        n = 0;
        while (stall && n < 20) begin
            n++;
            step();
        end
        check_eq("md_stall_cycles", n, 11);
        check_eq("md_busy_done", md_busy, 0);
        step();
        check_eq("md_mflo_E", rIR_E, 12);

        // reset while a divide is running
        md_start_D = 1'b1; md_div_D = 1'b1; md_use_D = 1'b1;
        set_d(5'd1, 5'd2, 5'd0, 1'b0, 2'd0);
        step();
        md_start_D = 1'b0; md_div_D = 1'b0; md_use_D = 1'b0;
        set_d(5'd3, 5'd4, 5'd7, 1'b1, 2'd1);
        step();
        step();
        check_eq("md_busy_run", md_busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("md_rst_busy", md_busy, 0);
        check_eq("md_rst_rIRE", rIR_E, 0);
        check_eq("md_rst_rIRM", rIR_M, 0);
        step();
        rst_n = 1'b1;
        md_use_D = 1'b1;
        #1;
        check_eq("md_rst_stall", stall, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
